// File: rtl/fifo_1d_32to64_pkg.sv
// Shared types for the 32-to-64 packer: the 65-bit buffered word and the
// rule that builds it from the assembly register and the incoming half-word.
package fifo_1d_32to64_pkg;

  typedef struct packed {
    logic        half;
    logic [63:0] data;
  } word_t;

  // With a pending high half the new beat completes the word; otherwise the
  // beat is a lone last half placed in the upper lane with a zeroed lower lane.
  function automatic word_t make_word(input logic        hi_valid,
                                      input logic [31:0] hi,
                                      input logic [31:0] lo_in);
    word_t w;
    if (hi_valid) begin
      w.half = 1'b0;
      w.data = {hi, lo_in};
    end else begin
      w.half = 1'b1;
      w.data = {lo_in, 32'h0};
    end
    return w;
  endfunction

endpackage

// File: rtl/fifo_1d_32to64_fifo_2d.sv
// Generic two-entry register FIFO with valid/ready on both sides; the read
// side is driven straight from the head register.
module fifo_2d #(
  parameter int WIDTH = 65
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_wr_valid,
  output logic             o_wr_ready,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_rd_valid,
  input  logic             i_rd_ready
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;
  logic             w_push;
  logic             w_pop;

  // Ready depends only on stored occupancy, never on the read side this cycle.
  assign o_wr_ready = (r_count != 2'd2);
  assign o_rd_valid = (r_count != 2'd0);
  assign w_push     = i_wr_valid & o_wr_ready;
  assign w_pop      = o_rd_valid & i_rd_ready;
  assign o_rd_data  = r_mem[r_rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; contents are only observed while o_rd_valid is high.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

endmodule

// File: rtl/fifo_1d_32to64.sv
// Packs 32-bit half-words into 64-bit words (first half in the upper lane),
// with a_last flushing a lone half, buffered through a two-entry output FIFO.
module fifo_1d_32to64
  import fifo_1d_32to64_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a_data,
  input  logic        a_valid,
  input  logic        a_last,
  output logic        a_ready,
  output logic [63:0] b_data,
  output logic        b_half,
  output logic        b_valid,
  input  logic        b_ready
);

  logic [31:0] r_hi;
  logic        r_hi_valid;
  logic        w_accept;
  logic        w_push;
  logic        w_wr_ready;
  logic        w_rd_valid;
  word_t       w_push_word;
  word_t       w_head;

  assign a_ready     = w_wr_ready;
  assign w_accept    = a_valid & w_wr_ready;
  assign w_push      = w_accept & (r_hi_valid | a_last);
  assign w_push_word = make_word(r_hi_valid, r_hi, a_data);

  // A held high half is always completed by the next beat, whatever a_last says.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi_valid <= 1'b0;
    end else if (w_accept) begin
      r_hi_valid <= ~r_hi_valid & ~a_last;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept && !r_hi_valid) r_hi <= a_data;
  end

  fifo_2d #(
    .WIDTH(65)
  ) u_obuf (
    .clk       (clk),
    .rst       (rst),
    .i_wr_data (w_push_word),
    .i_wr_valid(w_push),
    .o_wr_ready(w_wr_ready),
    .o_rd_data (w_head),
    .o_rd_valid(w_rd_valid),
    .i_rd_ready(b_ready)
  );

  // b_half is masked so it reads zero whenever no word is presented.
  assign b_valid = w_rd_valid;
  assign b_data  = w_head.data;
  assign b_half  = w_rd_valid & w_head.half;

endmodule

// File: tb/tb_fifo_1d_32to64.sv
// Bench for the 32-to-64 packer: directed scenarios with literal expectations
// plus a long randomized run against a queue-based reference model.
module tb_fifo_1d_32to64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] a_data = 32'h0;
  logic        a_valid = 1'b0;
  logic        a_last = 1'b0;
  logic        a_ready;
  logic [63:0] b_data;
  logic        b_half;
  logic        b_valid;
  logic        b_ready = 1'b0;

  always #5 clk = ~clk;

  fifo_1d_32to64 dut (
    .clk    (clk),
    .rst    (rst),
    .a_data (a_data),
    .a_valid(a_valid),
    .a_last (a_last),
    .a_ready(a_ready),
    .b_data (b_data),
    .b_half (b_half),
    .b_valid(b_valid),
    .b_ready(b_ready)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chkint(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: words completed but not yet taken, in order.
  typedef struct {
    logic        half;
    logic [63:0] data;
  } exp_t;

  exp_t        q[$];
  logic        m_hi_pend = 1'b0;
  logic [31:0] m_hi = 32'h0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_hi_pend = 1'b0;
    end else begin
      if (b_valid && b_ready && q.size() != 0) void'(q.pop_front());
      if (a_valid && a_ready) begin
        if (m_hi_pend) begin
          q.push_back('{1'b0, {m_hi, a_data}});
          m_hi_pend = 1'b0;
        end else if (a_last) begin
          q.push_back('{1'b1, {a_data, 32'h0}});
        end else begin
          m_hi      = a_data;
          m_hi_pend = 1'b1;
        end
      end
    end
  end

  // Per-cycle comparison against the model, sampled on the falling edge.
  logic        hold_p = 1'b0;
  logic [63:0] hold_d = 64'h0;
  logic        hold_h = 1'b0;
  logic        win = 1'b0;
  logic        prev_bv = 1'b0;
  int          pops_win = 0;
  int          consec = 0;

  always @(negedge clk) begin
    if (rst) begin
      chk1("rst_b_valid", b_valid, 1'b0);
      chk1("rst_a_ready", a_ready, 1'b1);
      chk1("rst_b_half", b_half, 1'b0);
      hold_p  = 1'b0;
      prev_bv = 1'b0;
    end else begin
      chk1("a_ready", a_ready, q.size() != 2);
      chk1("b_valid", b_valid, q.size() != 0);
      if (b_valid && q.size() != 0) begin
        chk64("b_data", b_data, q[0].data);
        chk1("b_half", b_half, q[0].half);
      end
      if (hold_p) begin
        chk64("hold_data", b_data, hold_d);
        chk1("hold_half", b_half, hold_h);
      end
      hold_p = b_valid && !b_ready;
      hold_d = b_data;
      hold_h = b_half;
      if (win) begin
        if (b_valid && prev_bv) consec++;
        if (b_valid && b_ready) pops_win++;
      end
      prev_bv = b_valid;
    end
  end

  logic rnd_on = 1'b0;

  task automatic send(input logic [31:0] d, input logic last, output int retries);
    logic ok;
    a_data  = d;
    a_last  = last;
    a_valid = 1'b1;
    retries = 0;
    forever begin
      @(negedge clk);
      ok = a_ready;
      @(posedge clk);
      #1;
      if (rnd_on) b_ready = ($urandom_range(0, 3) != 0);
      if (ok) break;
      retries++;
      if (retries > 50) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: beat %h not accepted within 50 cycles", d);
        break;
      end
    end
    a_valid = 1'b0;
    a_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    a_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rnd_on) b_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int r;
    int tot;
    int idx;
    logic ok;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk1("post_rst_b_valid", b_valid, 1'b0);
    chk1("post_rst_a_ready", a_ready, 1'b1);
    chk1("post_rst_b_half", b_half, 1'b0);

    // Two beats form one full word, visible the cycle after the second beat.
    b_ready = 1'b1;
    send(32'h1111_1111, 1'b0, r);
    chk1("p1_no_word_yet", b_valid, 1'b0);
    send(32'h2222_2222, 1'b0, r);
    chk1("p1_valid", b_valid, 1'b1);
    chk64("p1_data", b_data, 64'h1111_1111_2222_2222);
    chk1("p1_half", b_half, 1'b0);
    idle(2);

    // Lone last half, then a pair terminated by last.
    send(32'hDEAD_BEEF, 1'b1, r);
    chk1("p2a_valid", b_valid, 1'b1);
    chk64("p2a_data", b_data, 64'hDEAD_BEEF_0000_0000);
    chk1("p2a_half", b_half, 1'b1);
    idle(1);
    send(32'h0000_000A, 1'b0, r);
    send(32'h0000_000B, 1'b1, r);
    chk64("p2b_data", b_data, 64'h0000_000A_0000_000B);
    chk1("p2b_half", b_half, 1'b0);
    idle(2);

    // Backpressure: six beats offered with b_ready low, four fit.
    b_ready = 1'b0;
    idx = 0;
    a_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      a_data = 32'hC000_0000 + idx;
      @(negedge clk);
      ok = a_ready;
      @(posedge clk);
      #1;
      if (ok) idx++;
    end
    chkint("p3_accepted", idx, 4);
    chk1("p3_a_ready_low", a_ready, 1'b0);
    chk64("p3_head", b_data, 64'hC000_0000_C000_0001);
    b_ready = 1'b1;
    for (int c = 0; c < 20 && idx < 6; c++) begin
      a_data = 32'hC000_0000 + idx;
      @(negedge clk);
      ok = a_ready;
      @(posedge clk);
      #1;
      if (ok) idx++;
    end
    a_valid = 1'b0;
    chkint("p3_all_accepted", idx, 6);
    idle(6);
    chk1("p3_drained", b_valid, 1'b0);

    // Sustained streaming: 16 beats, 8 words, no stalls.
    tot = 0;
    pops_win = 0;
    consec = 0;
    win = 1'b1;
    for (int i = 0; i < 16; i++) begin
      send(32'h5000_0000 + i, 1'b0, r);
      tot += r;
    end
    @(negedge clk);
    #1;
    win = 1'b0;
    chkint("p4_stalls", tot, 0);
    chkint("p4_words", pops_win, 8);
    chkint("p4_back_to_back_valid", consec, 0);
    idle(3);

    // Asynchronous reset with a buffered word and a pending half.
    b_ready = 1'b0;
    send(32'h5, 1'b0, r);
    send(32'h6, 1'b0, r);
    send(32'h7, 1'b0, r);
    chk1("p5_pre_valid", b_valid, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk1("p5_async_b_valid", b_valid, 1'b0);
    chk1("p5_async_a_ready", a_ready, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    b_ready = 1'b1;
    send(32'h3, 1'b0, r);
    send(32'h4, 1'b0, r);
    chk1("p5_valid", b_valid, 1'b1);
    chk64("p5_data", b_data, 64'h0000_0003_0000_0004);
    chk1("p5_half", b_half, 1'b0);
    @(posedge clk);
    #1;
    chk1("p5_only_one", b_valid, 1'b0);
    idle(2);

    // Randomized throttling on both sides.
    rnd_on = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      send($urandom, ($urandom_range(0, 4) == 0), r);
    end
    rnd_on = 1'b0;
    b_ready = 1'b1;
    idle(6);
    chk1("rand_drained", b_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
